// File: rtl/data_mem_responder_pkg.sv
// Shared opcode values and responder state type for the MIPS load/store path.
package data_mem_responder_pkg;

  localparam logic [5:0] OPCODE_LW = 6'h23;
  localparam logic [5:0] OPCODE_SW = 6'h2b;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  function automatic logic is_mem_opcode(input logic [5:0] op);
    return (op == OPCODE_LW) || (op == OPCODE_SW);
  endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// Single-port synchronous word RAM; contents survive reset.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// LW/SW responder: checks the request at accept, waits LATENCY cycles, then
// performs one word access and holds the response until it is consumed.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  dmem_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic          req_ready_q;
  logic          resp_valid_q;
  logic          resp_err_q;
  logic          rd_ok_q;
  logic          is_sw_q;
  logic          err_q;
  logic [AW-1:0] widx_q;
  logic [31:0]   wdata_q;
  logic          req_err_d;
  logic          ram_we;
  logic [31:0]   ram_rdata;

  always_comb begin
    req_err_d = 1'b0;
    if (req_addr[1:0] != 2'b00) begin
      req_err_d = 1'b1;
    end
    if ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS)) begin
      req_err_d = 1'b1;
    end
    if (!is_mem_opcode(req_opcode)) begin
      req_err_d = 1'b1;
    end
  end

  // Gated by BUSY so an asynchronous reset before the access edge suppresses the write.
  assign ram_we = (state_q == DMEM_BUSY) && (cnt_q == '0) && is_sw_q && !err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DMEM_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rd_ok_q      <= 1'b0;
      is_sw_q      <= 1'b0;
      err_q        <= 1'b0;
      widx_q       <= '0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        DMEM_IDLE: begin
          if (req_valid) begin
            state_q     <= DMEM_BUSY;
            req_ready_q <= 1'b0;
            cnt_q       <= CNT_LOAD;
            is_sw_q     <= (req_opcode == OPCODE_SW);
            err_q       <= req_err_d;
            widx_q      <= req_addr[AW+1:2];
            wdata_q     <= req_wdata;
          end
        end
        DMEM_BUSY: begin
          if (cnt_q == '0) begin
            state_q      <= DMEM_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= err_q;
            rd_ok_q      <= !err_q && !is_sw_q;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DMEM_RESP: begin
          if (resp_ready) begin
            state_q      <= DMEM_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rd_ok_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= DMEM_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .addr (widx_q),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  // RAM read register holds its word throughout RESP since the address is frozen.
  assign resp_rdata = rd_ok_q ? ram_rdata : '0;
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder at LATENCY 2 and 1 against a word-array model.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT [2] = '{2, 1};

  logic        clk;
  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [5:0]  req_opcode [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  logic [31:0] mem_m [2][DEPTH];
  int checks = 0;
  int errors = 0;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut_l2 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_opcode(req_opcode[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_opcode(req_opcode[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input int d, input string tag);
    check({tag, "_ready"}, 32'(req_ready[d]), 32'd1);
    check({tag, "_valid"}, 32'(resp_valid[d]), 32'd0);
    check({tag, "_rdata"}, resp_rdata[d], 32'd0);
    check({tag, "_err"}, 32'(resp_err[d]), 32'd0);
  endtask

  // One complete request/response; stall = cycles resp_ready is withheld in RESP.
  task automatic xact(input int d, input logic [5:0] op, input logic [31:0] addr,
                      input logic [31:0] wd, input int stall);
    logic        err_e;
    logic [31:0] rd_e;
    int          n;
    err_e = (addr % 4 != 0) || ((addr / 4) >= DEPTH) || !(op == OPCODE_LW || op == OPCODE_SW);
    rd_e  = 32'd0;
    if (!err_e) begin
      if (op == OPCODE_SW) mem_m[d][addr / 4] = wd;
      else                 rd_e = mem_m[d][addr / 4];
    end
    check("ready_idle", 32'(req_ready[d]), 32'd1);
    req_opcode[d] = op;
    req_addr[d]   = addr;
    req_wdata[d]  = wd;
    req_valid[d]  = 1'b1;
    @(posedge clk); #1;
    req_valid[d]  = 1'b0;
    req_opcode[d] = OPCODE_SW;
    req_addr[d]   = $urandom;
    req_wdata[d]  = $urandom;
    n = 0;
    while (resp_valid[d] !== 1'b1 && n < 20) begin
      check("busy_ready", 32'(req_ready[d]), 32'd0);
      resp_ready[d] = 1'($urandom % 2);
      @(posedge clk); #1;
      n++;
    end
    resp_ready[d] = 1'b0;
    check("latency", 32'(n), 32'(LAT[d]));
    check("rdata", resp_rdata[d], rd_e);
    check("err", 32'(resp_err[d]), 32'(err_e));
    for (int i = 0; i < stall; i++) begin
      req_opcode[d] = OPCODE_SW;
      req_addr[d]   = {22'd0, 8'($urandom), 2'b00};
      req_wdata[d]  = $urandom;
      req_valid[d]  = 1'b1;
      @(posedge clk); #1;
      check("stall_valid", 32'(resp_valid[d]), 32'd1);
      check("stall_rdata", resp_rdata[d], rd_e);
      check("stall_err", 32'(resp_err[d]), 32'(err_e));
      check("stall_ready", 32'(req_ready[d]), 32'd0);
    end
    req_valid[d]  = 1'b0;
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    check_idle(d, "done");
  endtask

  // SW 0x20 dropped by reset while BUSY; the word must keep its previous value.
  task automatic reset_busy(input int d);
    req_opcode[d] = OPCODE_SW;
    req_addr[d]   = 32'h20;
    req_wdata[d]  = 32'h1234_5678;
    req_valid[d]  = 1'b1;
    @(posedge clk); #1;
    req_valid[d]  = 1'b0;
    check("rst_busy_ready", 32'(req_ready[d]), 32'd0);
    @(negedge clk);
    rst_n[d] = 1'b0;
    #1;
    check_idle(d, "rst_now");
    @(posedge clk); #1;
    check_idle(d, "rst_hold");
    @(negedge clk);
    rst_n[d] = 1'b1;
    @(posedge clk); #1;
    check_idle(d, "rst_after");
    xact(d, OPCODE_LW, 32'h20, 32'd0, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom % 8)
      0, 1, 2, 3, 4: a = {22'd0, 8'($urandom), 2'b00};
      5:             a = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
      6:             a = 32'h400 + 32'($urandom % 4096);
      default:       a = 32'hFFFF_FFFC - 32'(4 * ($urandom % 16));
    endcase
    return a;
  endfunction

  function automatic logic [5:0] rand_op();
    logic [5:0] o;
    case ($urandom % 8)
      0, 1, 2: o = OPCODE_LW;
      3, 4, 5: o = OPCODE_SW;
      6:       o = 6'h00;
      default: o = 6'($urandom);
    endcase
    return o;
  endfunction

  initial begin
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; resp_ready[d] = 1'b0;
      req_opcode[d] = '0; req_addr[d] = '0; req_wdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_idle(0, "reset_l2");
    check_idle(1, "reset_l1");
    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < int'(DEPTH); w++)
        xact(d, OPCODE_SW, 32'(w * 4), $urandom, 0);

    xact(0, OPCODE_SW, 32'h10, 32'hDEAD_BEEF, 0);
    xact(0, OPCODE_LW, 32'h10, 32'd0, 0);
    xact(0, OPCODE_LW, 32'h13, 32'd0, 0);
    xact(0, OPCODE_SW, 32'h402, 32'hCAFE_F00D, 0);
    xact(0, OPCODE_LW, 32'h400, 32'd0, 0);
    xact(0, OPCODE_LW, 32'h3FC, 32'd0, 0);
    xact(0, OPCODE_LW, 32'h000, 32'd0, 0);
    xact(0, 6'h00, 32'h10, 32'h1111_1111, 0);
    xact(0, OPCODE_LW, 32'h10, 32'd0, 0);
    xact(0, OPCODE_SW, 32'hFFFF_FFFC, 32'h2222_2222, 0);
    xact(0, OPCODE_LW, 32'hFFFF_FFFC, 32'd0, 0);
    xact(0, OPCODE_LW, 32'h10, 32'd0, 5);

    reset_busy(0);
    reset_busy(1);

    for (int i = 0; i < 8; i++) begin
      a = {22'd0, 8'($urandom), 2'b00};
      xact(1, OPCODE_SW, a, $urandom, 0);
      xact(1, OPCODE_LW, a, 32'd0, 0);
    end

    for (int i = 0; i < 300; i++) begin
      for (int d = 0; d < 2; d++)
        xact(d, rand_op(), rand_addr(), $urandom, int'($urandom % 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
